// File: rtl/masku_result_packer.sv
// Mask-unit write-back: packs sequential mask bits into DW-bit words, shuffles each
// word into the VRF lane layout for the destination EEW and issues per-lane writes.
package masku_pkg;
   localparam int unsigned ELEN = 64;
   typedef enum logic [1:0] {EW8 = 2'd0, EW16 = 2'd1, EW32 = 2'd2, EW64 = 2'd3} vew_e;
   typedef logic [15:0]     vlen_t;
   typedef logic [ELEN-1:0] elen_t;
   typedef logic [ELEN/8-1:0] strb_t;
endpackage

module masku_result_packer
   import masku_pkg::*;
#(
   parameter int unsigned NrLanes = 4,
   parameter type vaddr_t = logic [31:0]
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  vlen_t                     vl_i,
   input  vew_e                      vsew_i,
   input  vew_e                      eew_vd_i,
   input  vaddr_t                    vd_addr_i,
   output logic                      busy_o,
   output logic                      done_o,
   input  logic                      bits_valid_i,
   output logic                      bits_ready_o,
   input  logic [NrLanes*ELEN-1:0]   bits_i,
   output logic [NrLanes-1:0]        result_valid_o,
   input  logic [NrLanes-1:0]        result_ready_i,
   output elen_t [NrLanes-1:0]       result_wdata_o,
   output strb_t [NrLanes-1:0]       result_be_o,
   output vaddr_t [NrLanes-1:0]      result_addr_o
);

   localparam int unsigned DW   = NrLanes * ELEN;
   localparam int unsigned NB   = DW / 8;
   localparam int unsigned PtrW = $clog2(DW) + 1;

   typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_e;

   // Element e of width 2^ew bytes lives in lane e % NrLanes, slot e / NrLanes.
   function automatic int unsigned shuffle_index(input int unsigned b, input vew_e ew);
      int unsigned esz;
      int unsigned e;
      int unsigned k;
      esz = 32'd1 << ew;
      e   = b >> ew;
      k   = b & (esz - 32'd1);
      return (e % NrLanes) * 8 + (e / NrLanes) * esz + k;
   endfunction

   state_e            r_state;
   state_e            w_state_nxt;
   vlen_t             r_rem;
   vew_e              r_vsew;
   vew_e              r_eew;
   vaddr_t            r_base;
   vaddr_t            r_widx;
   logic [PtrW-1:0]   r_ptr;
   logic [DW-1:0]     r_acc;
   logic [NrLanes-1:0] r_lane_done;

   logic [PtrW-1:0]   w_beat_max;
   logic [PtrW-1:0]   w_n;
   logic [PtrW-1:0]   w_ptr_nxt;
   vlen_t             w_rem_nxt;
   logic [DW-1:0]     w_acc_nxt;
   logic              w_fire;
   logic              w_word_full;
   logic [DW-1:0]     w_shuf;
   logic [NB-1:0]     w_be;
   logic [NrLanes-1:0] w_lane_need;
   logic [NrLanes-1:0] w_lane_vld;
   logic [NrLanes-1:0] w_lane_fin;
   logic              w_all_fin;

   assign w_beat_max  = PtrW'(DW) >> r_vsew;
   assign w_n         = (vlen_t'(w_beat_max) > r_rem) ? PtrW'(r_rem) : w_beat_max;
   // Bits above n are masked off so the accumulator tail stays zero.
   assign w_acc_nxt   = r_acc | ((bits_i & ~({DW{1'b1}} << w_n)) << r_ptr);
   assign w_ptr_nxt   = r_ptr + w_n;
   assign w_rem_nxt   = r_rem - vlen_t'(w_n);
   assign w_fire      = bits_valid_i && (r_state == PACK);
   assign w_word_full = (w_ptr_nxt == PtrW'(DW)) || (w_rem_nxt == '0);

   always_comb begin
      int unsigned s;
      w_shuf = '0;
      w_be   = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         s = shuffle_index(b, r_eew);
         w_shuf[8*s +: 8] = r_acc[8*b +: 8];
         w_be[s]          = PtrW'(8 * b) < r_ptr;
      end
   end

   always_comb begin
      for (int l = 0; l < NrLanes; l++) begin
         w_lane_need[l] = |w_be[8*l +: 8];
      end
   end

   assign w_lane_vld = (r_state == DRAIN) ? (w_lane_need & ~r_lane_done) : '0;
   assign w_lane_fin = ~w_lane_need | r_lane_done | (w_lane_vld & result_ready_i);
   assign w_all_fin  = &w_lane_fin;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_nxt = (vl_i == '0) ? DONE : PACK;
            end
         end
         PACK: begin
            if (w_fire && w_word_full) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_all_fin) begin
               w_state_nxt = (r_rem == '0) ? DONE : PACK;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_rem       <= '0;
         r_vsew      <= EW8;
         r_eew       <= EW8;
         r_base      <= '0;
         r_widx      <= '0;
         r_ptr       <= '0;
         r_acc       <= '0;
         r_lane_done <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_rem       <= vl_i;
                  r_vsew      <= vsew_i;
                  r_eew       <= eew_vd_i;
                  r_base      <= vd_addr_i;
                  r_widx      <= '0;
                  r_ptr       <= '0;
                  r_acc       <= '0;
                  r_lane_done <= '0;
               end
            end
            PACK: begin
               if (w_fire) begin
                  r_acc <= w_acc_nxt;
                  r_ptr <= w_ptr_nxt;
                  r_rem <= w_rem_nxt;
               end
            end
            DRAIN: begin
               if (w_all_fin) begin
                  r_lane_done <= '0;
                  r_widx      <= r_widx + vaddr_t'(1);
                  r_ptr       <= '0;
                  r_acc       <= '0;
               end else begin
                  r_lane_done <= r_lane_done | (w_lane_vld & result_ready_i);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o         = (r_state == PACK) || (r_state == DRAIN);
   assign done_o         = (r_state == DONE);
   assign bits_ready_o   = (r_state == PACK);
   assign result_valid_o = w_lane_vld;

   always_comb begin
      for (int l = 0; l < NrLanes; l++) begin
         result_wdata_o[l] = w_shuf[ELEN*l +: ELEN];
         result_be_o[l]    = w_be[8*l +: 8];
         result_addr_o[l]  = r_base + r_widx;
      end
   end

endmodule

// File: tb/tb_masku_result_packer.sv
// Bench for masku_result_packer: table of instructions, per-lane write scoreboard
// filled by an inverse-shuffle model, plus vl=0 and reset-in-drain sequences.
module tb_masku_result_packer;
   import masku_pkg::*;

   localparam int NL = 4;
   localparam int DW = 256;

   logic                 clk = 1'b0;
   logic                 rst_i, start_i, bits_valid_i;
   vlen_t                vl_i;
   vew_e                 vsew_i, eew_vd_i;
   logic [31:0]          vd_addr_i;
   logic                 busy_o, done_o, bits_ready_o;
   logic [DW-1:0]        bits_i;
   logic [NL-1:0]        result_valid_o, result_ready_i;
   elen_t [NL-1:0]       result_wdata_o;
   strb_t [NL-1:0]       result_be_o;
   logic [NL-1:0][31:0]  result_addr_o;

   always #5 clk = ~clk;

   masku_result_packer #(.NrLanes(NL)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .vl_i(vl_i), .vsew_i(vsew_i),
      .eew_vd_i(eew_vd_i), .vd_addr_i(vd_addr_i), .busy_o(busy_o), .done_o(done_o),
      .bits_valid_i(bits_valid_i), .bits_ready_o(bits_ready_o), .bits_i(bits_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_wdata_o(result_wdata_o), .result_be_o(result_be_o),
      .result_addr_o(result_addr_o)
   );

   typedef struct {
      logic [31:0] addr;
      strb_t       be;
      elen_t       data;
   } wr_t;

   typedef struct {
      int          vl;
      vew_e        vsew;
      vew_e        eew;
      logic [31:0] base;
      int          pat;
      int          stall_lane;
      int          stall_cyc;
      bit          abort;
      int          exp_wr;
      int          exp_done;
   } vec_t;

   wr_t  exp_q [NL][$];
   logic hold [NL];
   wr_t  held [NL];
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_wr     = 0;
   int   n_done   = 0;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Sequential byte held at (lane, offset) for a given destination EEW.
   function automatic int seq_byte(input int lane, input int off, input int eew);
      int esz;
      esz = 1 << eew;
      return ((off / esz) * NL + lane) * esz + (off % esz);
   endfunction

   task automatic model(input int vl, input int eew, input logic [31:0] base,
                        input logic [1023:0] stream);
      for (int w = 0; w * DW < vl; w++) begin
         int nb;
         nb = vl - w * DW;
         if (nb > DW) nb = DW;
         for (int l = 0; l < NL; l++) begin
            wr_t e;
            e.addr = base + 32'(w);
            e.be   = '0;
            e.data = '0;
            for (int o = 0; o < 8; o++) begin
               int b;
               b = seq_byte(l, o, eew);
               for (int i = 0; i < 8; i++) begin
                  if (8 * b + i < nb) begin
                     e.be[o]         = 1'b1;
                     e.data[8*o + i] = stream[w * DW + 8 * b + i];
                  end
               end
            end
            if (e.be != '0) exp_q[l].push_back(e);
         end
      end
   endtask

   task automatic mon();
      if (done_o) begin
         n_done++;
         chk("busy_at_done", 64'(busy_o), 64'd0);
      end
      if (|result_valid_o) chk("bits_ready_in_drain", 64'(bits_ready_o), 64'd0);
      for (int l = 0; l < NL; l++) begin
         wr_t cur;
         cur.addr = result_addr_o[l];
         cur.be   = result_be_o[l];
         cur.data = result_wdata_o[l];
         if (result_valid_o[l]) begin
            if (hold[l]) begin
               chk("hold_data", cur.data, held[l].data);
               chk("hold_be", 64'(cur.be), 64'(held[l].be));
               chk("hold_addr", 64'(cur.addr), 64'(held[l].addr));
            end
            if (result_ready_i[l]) begin
               n_wr++;
               hold[l] = 1'b0;
               if (exp_q[l].size() == 0) begin
                  chk("unexpected_write", 64'(result_valid_o[l]), 64'd0);
               end else begin
                  wr_t e;
                  e = exp_q[l].pop_front();
                  chk("wr_addr", 64'(cur.addr), 64'(e.addr));
                  chk("wr_be", 64'(cur.be), 64'(e.be));
                  chk("wr_data", cur.data, e.data);
               end
            end else begin
               hold[l] = 1'b1;
               held[l] = cur;
            end
         end else if (hold[l]) begin
            chk("valid_dropped", 64'(result_valid_o[l]), 64'd1);
            hold[l] = 1'b0;
         end
      end
   endtask

   task automatic run(input vec_t v);
      logic [1023:0] stream;
      logic [DW-1:0] m, g;
      int sent, n, bw, stall, wr0, done0;
      bit fin;
      for (int i = 0; i < 32; i++) stream[32*i +: 32] = $urandom;
      if (v.pat == 0) for (int b = 0; b < 32; b++) stream[8*b +: 8] = 8'(b / 8 + 1);
      model(v.vl, int'(v.eew), v.base, stream);
      wr0   = n_wr;
      done0 = n_done;
      sent  = 0;
      stall = v.stall_cyc;
      bw    = DW >> int'(v.vsew);
      fin   = 1'b0;
      @(posedge clk); #1;
      start_i        = 1'b1;
      vl_i           = 16'(v.vl);
      vsew_i         = v.vsew;
      eew_vd_i       = v.eew;
      vd_addr_i      = v.base;
      bits_valid_i   = 1'b0;
      result_ready_i = v.abort ? '0 : '1;
      if (v.stall_lane >= 0 && stall > 0) result_ready_i[v.stall_lane] = 1'b0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         @(negedge clk);
         mon();
         if (done_o) begin
            fin = 1'b1;
         end else if (v.abort && |result_valid_o) begin
            @(posedge clk); #1;
            rst_i        = 1'b1;
            start_i      = 1'b0;
            bits_valid_i = 1'b0;
            @(posedge clk); #1;
            rst_i = 1'b0;
            @(negedge clk);
            chk("rst_valid", 64'(result_valid_o), 64'd0);
            chk("rst_busy", 64'(busy_o), 64'd0);
            chk("rst_ready", 64'(bits_ready_o), 64'd0);
            chk("rst_done", 64'(done_o), 64'd0);
            for (int l = 0; l < NL; l++) begin
               exp_q[l].delete();
               hold[l] = 1'b0;
            end
            fin = 1'b1;
         end
         if (!fin) begin
            n = (v.vl - sent < bw) ? v.vl - sent : bw;
            if (bits_valid_i && bits_ready_o) sent += n;
            if (v.stall_lane >= 0 && stall > 0 && result_valid_o[v.stall_lane]) stall--;
            @(posedge clk); #1;
            // A start while busy must be ignored.
            start_i = (cyc == 2) && busy_o;
            if (start_i) vl_i = 16'd5;
            n = (v.vl - sent < bw) ? v.vl - sent : bw;
            m = ~({DW{1'b1}} << n);
            for (int i = 0; i < 8; i++) g[32*i +: 32] = $urandom;
            bits_valid_i   = sent < v.vl;
            bits_i         = (DW'(stream >> sent) & m) | (g & ~m);
            result_ready_i = v.abort ? '0 : '1;
            if (v.stall_lane >= 0 && stall > 0) result_ready_i[v.stall_lane] = 1'b0;
         end
      end
      if (!fin) chk("done_timeout", 64'(done_o), 64'd1);
      start_i        = 1'b0;
      bits_valid_i   = 1'b0;
      result_ready_i = '1;
      repeat (3) begin
         @(negedge clk);
         mon();
      end
      chk("write_count", 64'(n_wr - wr0), 64'(v.exp_wr));
      chk("done_count", 64'(n_done - done0), 64'(v.exp_done));
      for (int l = 0; l < NL; l++) chk("leftover_writes", 64'(exp_q[l].size()), 64'd0);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; vl_i = '0; vsew_i = EW8; eew_vd_i = EW8;
      vd_addr_i = '0; bits_valid_i = 1'b0; bits_i = '0; result_ready_i = '1;
      for (int l = 0; l < NL; l++) hold[l] = 1'b0;

      tbl[0] = '{256, EW64, EW64, 32'h10,       0, -1, 0, 1'b0, 4,  1};
      tbl[1] = '{70,  EW8,  EW64, 32'h30,       1, -1, 0, 1'b0, 2,  1};
      tbl[2] = '{256, EW64, EW64, 32'h10,       0,  2, 5, 1'b0, 4,  1};
      tbl[3] = '{600, EW8,  EW64, 32'h20,       1, -1, 0, 1'b0, 10, 1};
      tbl[4] = '{100, EW16, EW8,  32'h7,        1, -1, 0, 1'b0, 4,  1};
      tbl[5] = '{300, EW32, EW16, 32'hFFFFFFFF, 1, -1, 0, 1'b0, 7,  1};
      tbl[6] = '{64,  EW64, EW32, 32'h55,       1,  0, 3, 1'b0, 2,  1};
      tbl[7] = '{1,   EW32, EW64, 32'h99,       1,  1, 2, 1'b0, 1,  1};
      tbl[8] = '{256, EW64, EW64, 32'h40,       1, -1, 0, 1'b1, 0,  0};
      tbl[9] = '{64,  EW64, EW64, 32'h80,       1, -1, 0, 1'b0, 1,  1};

      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_done", 64'(done_o), 64'd0);
      chk("reset_ready", 64'(bits_ready_o), 64'd0);
      chk("reset_valid", 64'(result_valid_o), 64'd0);

      for (int i = 0; i < 10; i++) run(tbl[i]);

      // vl=0: done one cycle after the start edge, nothing else happens.
      @(posedge clk); #1;
      start_i = 1'b1;
      vl_i    = '0;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("vl0_done", 64'(done_o), (i == 0) ? 64'd1 : 64'd0);
         chk("vl0_busy", 64'(busy_o), 64'd0);
         chk("vl0_ready", 64'(bits_ready_o), 64'd0);
         chk("vl0_valid", 64'(result_valid_o), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
